// File: rtl/imem_if.sv
// Instruction-fetch request/response channel between a fetch stage (master)
// and an instruction memory (slave).
interface imem_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic        imem_resp_ready;
  logic [31:0] imem_resp_inst;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    output imem_resp_ready,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_inst
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    input  imem_resp_ready,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_inst
  );
endinterface

// File: rtl/imem_responder.sv
// Credit-limited instruction memory responder: fixed-latency read pipeline feeding an in-order
// response FIFO. Define IMEM_STALL_INJECT_EN to add pseudo-random request stalls.
module imem_responder #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned QDEPTH   = 4,
  parameter logic [31:0] OOR_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  imem_if.slave       imem_s,
  input  logic        flush,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(QDEPTH + 1);
  localparam int unsigned QW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  // The FIFO itself is the last register stage, so the pipe holds LATENCY-1 stages.
  localparam int unsigned PIPE = (LATENCY > 1) ? LATENCY - 1 : 1;

  logic [31:0]     mem [DEPTH];
  logic [CW-1:0]   cnt_q;
  logic [PIPE-1:0] pipe_valid_q;
  logic [31:0]     pipe_data_q [PIPE];
  logic [31:0]     fifo_mem [QDEPTH];
  logic [QW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   fifo_cnt_q;

  logic            stall;
  logic            req_ready;
  logic            accept;
  logic            resp_valid;
  logic            pop;
  logic            push_valid;
  logic [31:0]     push_data;
  logic [31:0]     rd_word;
  logic            rd_oor;
  logic            prog_oor;

`ifdef IMEM_STALL_INJECT_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b11);
`else
  assign stall = 1'b0;
`endif

  assign req_ready  = !rst && !flush && !stall && (cnt_q < CW'(QDEPTH));
  assign accept     = imem_s.imem_req_valid && req_ready;
  assign resp_valid = (fifo_cnt_q != '0);
  assign pop        = resp_valid && imem_s.imem_resp_ready && !flush;

  assign rd_oor   = (imem_s.imem_req_addr >> 2) >= 32'(DEPTH);
  assign prog_oor = (prog_addr >> 2) >= 32'(DEPTH);
  assign rd_word  = rd_oor ? OOR_INST : mem[imem_s.imem_req_addr[2 +: AW]];

  assign push_valid = (LATENCY == 1) ? accept  : pipe_valid_q[PIPE-1];
  assign push_data  = (LATENCY == 1) ? rd_word : pipe_data_q[PIPE-1];

  assign imem_s.imem_req_ready  = req_ready;
  assign imem_s.imem_resp_valid = resp_valid;
  assign imem_s.imem_resp_inst  = resp_valid ? fifo_mem[rd_ptr_q] : '0;

  // Store is not reset; a read in the write cycle sees the old word.
  always_ff @(posedge clk) begin
    if (prog_we && !prog_oor) begin
      mem[prog_addr[2 +: AW]] <= prog_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid_q <= '0;
    end else if (flush) begin
      pipe_valid_q <= '0;
    end else begin
      pipe_valid_q[0] <= accept;
      for (int i = 1; i < PIPE; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_data_q[0] <= rd_word;
    for (int i = 1; i < PIPE; i++) begin
      pipe_data_q[i] <= pipe_data_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(accept) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push_valid) begin
        wr_ptr_q <= (wr_ptr_q == QW'(QDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == QW'(QDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      fifo_cnt_q <= fifo_cnt_q + CW'(push_valid) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_valid && !flush) begin
      fifo_mem[wr_ptr_q] <= push_data;
    end
  end

  // Credits cover pipeline plus FIFO, so a push can never meet a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push_valid && (fifo_cnt_q == CW'(QDEPTH)) && !pop));
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed-vector bench for imem_responder at default parameters (DEPTH 1024, LATENCY 2,
// QDEPTH 4), stall injection disabled.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;

  int n_vec = 0;
  int n_err = 0;

  imem_if bus ();

  imem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .imem_s    (bus),
    .flush     (flush),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  always #5 clk = ~clk;

  // Cycle-by-cycle vectors for the addressing / program-load section.
  logic [7:0]  v4_req_v  = 8'b0010_1111;  // bit c = cycle c
  logic [7:0]  v4_pw     = 8'b0001_0100;
  logic [7:0]  v4_exp_v  = 8'b1011_1100;
  logic [31:0] v4_req_a [8] = '{32'h1000, 32'h7, 32'd20, 32'd20, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] v4_pa    [8] = '{32'h0, 32'h0, 32'd20, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h0};
  logic [31:0] v4_pd    [8] = '{32'h0, 32'h0, 32'h55AA55AA, 32'h0, 32'h00000BAD, 32'h0, 32'h0, 32'h0};
  logic [31:0] v4_exp_i [8] = '{32'h0, 32'h0, 32'h13, 32'h1, 32'h5, 32'h55AA55AA, 32'h0, 32'h0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic prog(input logic [31:0] addr, input logic [31:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  // With resp_ready low, offer four requests for six cycles: exactly four may be accepted and
  // the head must hold. Then drain and check order and credit return.
  task automatic fill_drain(input string tag,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] a2, input logic [31:0] a3,
                            input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] al [4];
    logic [31:0] el [4];
    int acc;
    al  = '{a0, a1, a2, a3};
    el  = '{e0, e1, e2, e3};
    acc = 0;
    bus.imem_resp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.imem_req_valid = 1'b1;
      bus.imem_req_addr  = al[(acc < 4) ? acc : 3];
      #1;
      if (c >= 2) begin
        check({tag, "_hold_valid"}, 32'(bus.imem_resp_valid), 32'd1);
        check({tag, "_hold_inst"}, bus.imem_resp_inst, e0);
      end
      if (bus.imem_req_ready) acc++;
      tick();
    end
    bus.imem_req_valid = 1'b0;
    check({tag, "_accepted"}, 32'(acc), 32'd4);
    bus.imem_resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k == 0) check({tag, "_full_ready"}, 32'(bus.imem_req_ready), 32'd0);
      if (k == 1) check({tag, "_ready_back"}, 32'(bus.imem_req_ready), 32'd1);
      check({tag, "_drain_valid"}, 32'(bus.imem_resp_valid), 32'd1);
      check({tag, "_drain_inst"}, bus.imem_resp_inst, el[k]);
      tick();
    end
    #1 check({tag, "_empty"}, 32'(bus.imem_resp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    bus.imem_req_valid  = 1'b0;
    bus.imem_req_addr   = '0;
    bus.imem_resp_ready = 1'b0;
    #2 rst = 1'b1;

    // Reset state
    tick();
    tick();
    #1;
    check("rst_ready", 32'(bus.imem_req_ready), 32'd0);
    check("rst_valid", 32'(bus.imem_resp_valid), 32'd0);
    check("rst_inst", bus.imem_resp_inst, 32'd0);
    tick();
    rst = 1'b0;
    #1 check("ready_after_rst", 32'(bus.imem_req_ready), 32'd1);
    tick();

    // Single request: response exactly two cycles later, single-cycle pulse
    prog(32'h0, 32'hDEADBEEF);
    bus.imem_req_valid  = 1'b1;
    bus.imem_req_addr   = 32'h0;
    bus.imem_resp_ready = 1'b1;
    #1 check("t1_ready", 32'(bus.imem_req_ready), 32'd1);
    tick();
    bus.imem_req_valid = 1'b0;
    #1 check("t1_lat1_valid", 32'(bus.imem_resp_valid), 32'd0);
    tick();
    #1;
    check("t1_valid", 32'(bus.imem_resp_valid), 32'd1);
    check("t1_inst", bus.imem_resp_inst, 32'hDEADBEEF);
    tick();
    #1 check("t1_pulse", 32'(bus.imem_resp_valid), 32'd0);
    tick();

    // Back-to-back streaming at full throughput
    for (int i = 0; i < 8; i++) prog(32'(4 * i), 32'(i));
    for (int c = 0; c < 10; c++) begin
      bus.imem_req_valid = (c < 8);
      bus.imem_req_addr  = 32'(4 * c);
      #1;
      if (c < 8) check("t2_ready", 32'(bus.imem_req_ready), 32'd1);
      if (c >= 2) begin
        check("t2_valid", 32'(bus.imem_resp_valid), 32'd1);
        check("t2_inst", bus.imem_resp_inst, 32'(c - 2));
      end else begin
        check("t2_early_valid", 32'(bus.imem_resp_valid), 32'd0);
      end
      tick();
    end
    #1 check("t2_done", 32'(bus.imem_resp_valid), 32'd0);
    tick();

    // Backpressure: credits exhaust at QDEPTH
    fill_drain("t3", 32'd0, 32'd4, 32'd8, 32'd12, 32'd0, 32'd1, 32'd2, 32'd3);
    tick();

    // Out-of-range read, ignored low bits, write/read collision, out-of-range write
    bus.imem_resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.imem_req_valid = v4_req_v[c];
      bus.imem_req_addr  = v4_req_a[c];
      prog_we   = v4_pw[c];
      prog_addr = v4_pa[c];
      prog_data = v4_pd[c];
      #1;
      check("t4_valid", 32'(bus.imem_resp_valid), 32'(v4_exp_v[c]));
      if (v4_exp_v[c]) check("t4_inst", bus.imem_resp_inst, v4_exp_i[c]);
      tick();
    end
    bus.imem_req_valid = 1'b0;
    prog_we = 1'b0;

    // Flush with responses pending
    bus.imem_resp_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.imem_req_valid = (c < 3);
      bus.imem_req_addr  = 32'(4 * (c + 1));
      tick();
    end
    bus.imem_req_valid = 1'b0;
    flush = 1'b1;
    bus.imem_resp_ready = 1'b1;
    #1;
    check("t5_pre_valid", 32'(bus.imem_resp_valid), 32'd1);
    check("t5_pre_inst", bus.imem_resp_inst, 32'd1);
    check("t5_flush_ready", 32'(bus.imem_req_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("t5_post_valid", 32'(bus.imem_resp_valid), 32'd0);
    check("t5_post_ready", 32'(bus.imem_req_ready), 32'd1);
    tick();
    #1 check("t5_no_stale", 32'(bus.imem_resp_valid), 32'd0);
    tick();
    fill_drain("t5", 32'd24, 32'd28, 32'd0, 32'd4, 32'd6, 32'd7, 32'd0, 32'd1);
    tick();

    // Asynchronous reset with two responses queued
    bus.imem_resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.imem_req_valid = (c < 2);
      bus.imem_req_addr  = 32'(4 * (c + 1));
      tick();
    end
    bus.imem_req_valid = 1'b0;
    #1 check("t6_queued", 32'(bus.imem_resp_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(bus.imem_resp_valid), 32'd0);
    check("t6_rst_inst", bus.imem_resp_inst, 32'd0);
    check("t6_rst_ready", 32'(bus.imem_req_ready), 32'd0);
    tick();
    rst = 1'b0;
    bus.imem_resp_ready = 1'b1;
    #1 check("t6_ready", 32'(bus.imem_req_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      #1 check("t6_no_stale", 32'(bus.imem_resp_valid), 32'd0);
    end
    tick();
    bus.imem_req_valid = 1'b1;
    bus.imem_req_addr  = 32'd12;
    tick();
    bus.imem_req_valid = 1'b0;
    tick();
    #1;
    check("t6_new_valid", 32'(bus.imem_resp_valid), 32'd1);
    check("t6_new_inst", bus.imem_resp_inst, 32'd3);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
